// File: rtl/alu_sequencer.sv
// Command-side sequencer for the registered 256-bit ALU: accepts tagged commands,
// screens opcodes, drives ALU inputs from registers and returns tagged responses.
module alu_sequencer #(
   parameter int OPCODE_WIDTH = 2,
   parameter int DATA_WIDTH   = 255,
   parameter int TAG_WIDTH    = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [OPCODE_WIDTH:0]   cmd_opcode,
   input  logic [DATA_WIDTH:0]     cmd_op1,
   input  logic [DATA_WIDTH:0]     cmd_op2,
   input  logic [TAG_WIDTH-1:0]    cmd_tag,
   output logic [OPCODE_WIDTH:0]   alu_opcode,
   output logic [DATA_WIDTH:0]     alu_op1,
   output logic [DATA_WIDTH:0]     alu_op2,
   input  logic [DATA_WIDTH:0]     alu_result,
   input  logic                    alu_carry,
   input  logic                    alu_zero,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH:0]     rsp_result,
   output logic                    rsp_carry,
   output logic                    rsp_zero,
   output logic                    rsp_err,
   output logic [TAG_WIDTH-1:0]    rsp_tag,
   output logic                    busy,
   output logic [15:0]             done_count,
   output logic [15:0]             err_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [OPCODE_WIDTH:0] MAX_OPCODE = 3;
   localparam logic [15:0]           COUNT_MAX  = 16'hFFFF;

   state_t state_reg;
   state_t state_next;
   logic   accept;
   logic   legal;
   logic   rsp_fire;

   assign cmd_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign accept    = cmd_valid && cmd_ready;
   assign legal     = (cmd_opcode <= MAX_OPCODE);
   assign rsp_fire  = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = legal ? EXEC : RESP;
            end
         end
         EXEC: state_next = CAPT;
         CAPT: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ALU inputs only move on a legal accept, so they hold the last legal command.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         alu_opcode <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
      end else if (accept && legal) begin
         alu_opcode <= cmd_opcode;
         alu_op1    <= cmd_op1;
         alu_op2    <= cmd_op2;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_tag    <= '0;
      end else begin
         if (accept) begin
            rsp_tag <= cmd_tag;
            if (!legal) begin
               rsp_result <= '0;
               rsp_carry  <= 1'b0;
               rsp_zero   <= 1'b0;
               rsp_err    <= 1'b1;
            end
         end
         // ALU outputs are sampled here and nowhere else.
         if (state_reg == CAPT) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done_count <= '0;
         err_count  <= '0;
      end else if (rsp_fire) begin
         if (rsp_err) begin
            if (err_count != COUNT_MAX) begin
               err_count <= err_count + 16'd1;
            end
         end else if (done_count != COUNT_MAX) begin
            done_count <= done_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven commands with a response
// scoreboard, a behavioural registered ALU, plus backpressure and reset-mid-op sequences.
module tb_alu_sequencer;

   localparam int OW = 2;
   localparam int DW = 255;
   localparam int TW = 4;
   localparam logic [255:0] ONES   = '1;
   localparam logic [255:0] MINUS2 = ONES - 256'd1;

   logic            clk = 1'b0;
   logic            rstn;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [OW:0]     cmd_opcode;
   logic [DW:0]     cmd_op1;
   logic [DW:0]     cmd_op2;
   logic [TW-1:0]   cmd_tag;
   logic [OW:0]     alu_opcode;
   logic [DW:0]     alu_op1;
   logic [DW:0]     alu_op2;
   logic [DW:0]     alu_result;
   logic            alu_carry;
   logic            alu_zero;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW:0]     rsp_result;
   logic            rsp_carry;
   logic            rsp_zero;
   logic            rsp_err;
   logic [TW-1:0]   rsp_tag;
   logic            busy;
   logic [15:0]     done_count;
   logic [15:0]     err_count;

   always #5 clk = ~clk;

   alu_sequencer #(.OPCODE_WIDTH(OW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_tag(cmd_tag),
      .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
      .busy(busy), .done_count(done_count), .err_count(err_count)
   );

   // Behavioural registered ALU: one cycle from inputs to RESULT/CARRY/ZERO.
   logic [DW+1:0] alu_full;
   always_comb begin
      alu_full = '0;
      case (alu_opcode)
         3'd0: alu_full = {1'b0, alu_op1} + {1'b0, alu_op2};
         3'd1: alu_full = {1'b0, alu_op1} - {1'b0, alu_op2};
         3'd2: alu_full = {1'b0, alu_op1} + 257'd1;
         3'd3: alu_full = {1'b0, alu_op1} - 257'd1;
         default: alu_full = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      alu_result <= alu_full[DW:0];
      alu_carry  <= alu_full[DW+1];
      alu_zero   <= (alu_full[DW:0] == '0);
   end

   typedef struct {
      logic [2:0]   opc;
      logic [255:0] op1;
      logic [255:0] op2;
      logic [3:0]   tag;
      int           hold;
      logic [255:0] res;
      logic         c;
      logic         z;
      logic         err;
   } vec_t;

   typedef struct {
      logic [255:0] res;
      logic         c;
      logic         z;
      logic         err;
      logic [3:0]   tag;
   } rsp_t;

   vec_t  vecs[9];
   rsp_t  sb_q[$];
   int    tests = 0;
   int    fails = 0;
   int    exp_done = 0;
   int    exp_err = 0;
   logic [2:0]   last_opc;
   logic [255:0] last_op1;
   logic [255:0] last_op2;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_alu_opcode"}, 256'(alu_opcode), 256'd0);
      chk({pfx, "_alu_op1"}, alu_op1, 256'd0);
      chk({pfx, "_alu_op2"}, alu_op2, 256'd0);
      chk({pfx, "_rsp_result"}, rsp_result, 256'd0);
      chk({pfx, "_rsp_flags_tag"}, 256'({rsp_valid, rsp_carry, rsp_zero, rsp_err, rsp_tag}), 256'd0);
      chk({pfx, "_busy_ready"}, 256'({busy, cmd_ready}), 256'b01);
      chk({pfx, "_counts"}, 256'({done_count, err_count}), 256'd0);
   endtask

   task automatic run_cmd(input vec_t v);
      int   lat;
      rsp_t e;
      logic [255:0] snap_res;
      logic [8:0]   snap_bits;
      @(negedge clk);
      lat = 0;
      while (!cmd_ready && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("cmd_ready_before", 256'(cmd_ready), 256'd1);
      cmd_valid  = 1'b1;
      cmd_opcode = v.opc;
      cmd_op1    = v.op1;
      cmd_op2    = v.op2;
      cmd_tag    = v.tag;
      e.res = v.res; e.c = v.c; e.z = v.z; e.err = v.err; e.tag = v.tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      cmd_opcode = 3'($urandom);
      cmd_op1    = {8{32'($urandom)}};
      cmd_op2    = {8{32'($urandom)}};
      cmd_tag    = 4'($urandom);
      if (!v.err) begin
         last_opc = v.opc;
         last_op1 = v.op1;
         last_op2 = v.op2;
      end
      @(negedge clk);
      chk("alu_opcode", 256'(alu_opcode), 256'(last_opc));
      chk("alu_op1", alu_op1, last_op1);
      chk("alu_op2", alu_op2, last_op2);
      chk("busy_after_accept", 256'({busy, cmd_ready}), 256'b10);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_latency", 256'(lat), v.err ? 256'd1 : 256'd3);
      snap_res  = rsp_result;
      snap_bits = {rsp_valid, rsp_carry, rsp_zero, rsp_err, rsp_tag, busy};
      for (int i = 0; i < v.hold; i++) begin
         cmd_valid  = i[0];
         cmd_opcode = 3'd0;
         cmd_tag    = 4'($urandom);
         @(negedge clk);
         chk("bp_cmd_ready", 256'(cmd_ready), 256'd0);
         chk("bp_result_stable", rsp_result, snap_res);
         chk("bp_flags_stable", 256'({rsp_valid, rsp_carry, rsp_zero, rsp_err, rsp_tag, busy}),
             256'(snap_bits));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 256'd0, 256'd1);
      end else begin
         e = sb_q.pop_front();
         chk("rsp_result", rsp_result, e.res);
         chk("rsp_flags", 256'({rsp_carry, rsp_zero, rsp_err}), 256'({e.c, e.z, e.err}));
         chk("rsp_tag", 256'(rsp_tag), 256'(e.tag));
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      if (v.err) exp_err++;
      else exp_done++;
      @(negedge clk);
      chk("ready_after_hs", 256'({cmd_ready, rsp_valid, busy}), 256'b100);
      chk("done_count", 256'(done_count), 256'(exp_done));
      chk("err_count", 256'(err_count), 256'(exp_err));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      vecs[0] = '{3'd0, ONES,      256'd1,  4'd3,  0,  256'd0,   1'b1, 1'b1, 1'b0};
      vecs[1] = '{3'd1, 256'd5,    256'd7,  4'd4,  10, MINUS2,   1'b1, 1'b0, 1'b0};
      vecs[2] = '{3'd2, 256'd41,   256'd99, 4'd5,  0,  256'd42,  1'b0, 1'b0, 1'b0};
      vecs[3] = '{3'd3, 256'd0,    256'd0,  4'd6,  1,  ONES,     1'b1, 1'b0, 1'b0};
      vecs[4] = '{3'd5, 256'd77,   256'd88, 4'd9,  3,  256'd0,   1'b0, 1'b0, 1'b1};
      vecs[5] = '{3'd0, 256'd100,  256'd23, 4'd10, 0,  256'd123, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{3'd1, 256'd7,    256'd7,  4'd11, 2,  256'd0,   1'b0, 1'b1, 1'b0};
      vecs[7] = '{3'd7, ONES,      ONES,    4'd15, 0,  256'd0,   1'b0, 1'b0, 1'b1};
      vecs[8] = '{3'd2, ONES,      256'd0,  4'd0,  0,  256'd0,   1'b1, 1'b1, 1'b0};

      rstn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_opcode = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_tag = '0;
      last_opc = '0; last_op1 = '0; last_op2 = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rstn = 1'b1;
      @(negedge clk);
      chk("ready_after_release", 256'(cmd_ready), 256'd1);

      for (int i = 0; i < 9; i++) begin
         run_cmd(vecs[i]);
      end

      // Reset while the command sits in EXEC.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_op1 = 256'd1; cmd_op2 = 256'd1; cmd_tag = 4'd7;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("midop_busy", 256'(busy), 256'd1);
      rstn = 1'b0;
      #1;
      check_reset_outputs("midop_reset");
      @(negedge clk);
      rstn = 1'b1;
      sb_q.delete();
      exp_done = 0; exp_err = 0;
      last_opc = '0; last_op1 = '0; last_op2 = '0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("midop_no_response", 256'(seen), 256'd0);
      run_cmd(vecs[5]);
      run_cmd(vecs[4]);

      chk("scoreboard_drained", 256'(sb_q.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
